// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader: FSM encodings,
// image framing sizes and the CPU entry address.
package loader_pkg;

    localparam logic [31:0] LOAD_ENTRY = 32'h8000_0000;
    localparam int          LEN_BYTES  = 4;
    localparam int          WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ST_LEN,
        ST_DATA,
        ST_DONE,
        ST_ERR
    } load_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling timer and LSB-first
// shifter. Emits a one-cycle rx_valid or frame_err pulse per received frame.
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic       o_valid,
    output logic [7:0] o_byte,
    output logic       o_frame_err
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_t        r_state;
    rx_state_t        w_state_nx;
    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_valid;
    logic [7:0]       r_byte;
    logic             r_ferr;
    logic             w_rx;
    logic             w_bit_tick;
    logic             w_stop_tick;

    assign w_rx        = r_sync[1];
    assign w_bit_tick  = (r_state == RX_DATA) && (r_cnt == LAST_CNT);
    assign w_stop_tick = (r_state == RX_STOP) && (r_cnt == LAST_CNT);

    // Returning to idle on the stop sample lets the next start edge be caught
    // half a bit later, so back-to-back frames are accepted.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            RX_IDLE:  if (!w_rx) w_state_nx = RX_START;
            RX_START: if (r_cnt == HALF_CNT) w_state_nx = w_rx ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_bit_tick && (r_bit == 3'd7)) w_state_nx = RX_STOP;
            RX_STOP:  if (w_stop_tick) w_state_nx = RX_IDLE;
            default:  w_state_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= RX_IDLE;
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_byte  <= '0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_rx};
            r_state <= w_state_nx;
            r_valid <= w_stop_tick && w_rx;
            r_ferr  <= w_stop_tick && !w_rx;
            if (w_stop_tick && w_rx) begin
                r_byte <= r_shift;
            end
            if ((r_state == RX_IDLE) || (w_state_nx != r_state) || w_bit_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_bit_tick) begin
                r_shift <= {w_rx, r_shift[7:1]};
                r_bit   <= r_bit + 1'b1;
            end
        end
    end

    assign o_valid     = r_valid;
    assign o_byte      = r_byte;
    assign o_frame_err = r_ferr;

endmodule

// File: rtl/uart_prog_loader.sv
// Serial program loader: receives a length-prefixed little-endian word image over
// UART, writes it into instruction memory and then releases the CPU.
module uart_prog_loader
    import loader_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int MEM_WORDS = 2056,
    parameter int ADDR_W    = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ser_rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    output logic              load_err,
    output logic [ADDR_W:0]   words_left
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

    logic              w_rx_valid;
    logic [7:0]        w_rx_byte;
    logic              w_frame_err;

    load_state_t       r_state;
    load_state_t       w_state_nx;
    logic [1:0]        r_lane;
    logic [23:0]       r_len;
    logic [23:0]       r_word;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W:0]   r_words_left;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_cpu_run;
    logic              r_load_err;
    logic              w_last_byte;
    logic              w_loading;
    logic [31:0]       w_len_full;
    logic [31:0]       w_word_full;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .i_clk       (clk),
        .i_rst       (reset),
        .i_rx        (ser_rx),
        .o_valid     (w_rx_valid),
        .o_byte      (w_rx_byte),
        .o_frame_err (w_frame_err)
    );

    // Earlier lanes are held in 24-bit shifters; the arriving byte completes the top lane.
    assign w_loading   = (r_state == ST_LEN) || (r_state == ST_DATA);
    assign w_last_byte = w_rx_valid && (r_lane == 2'd3);
    assign w_len_full  = {w_rx_byte, r_len};
    assign w_word_full = {w_rx_byte, r_word};

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_LEN: begin
                if (w_frame_err) begin
                    w_state_nx = ST_ERR;
                end else if (w_last_byte) begin
                    if (w_len_full == 32'd0) begin
                        w_state_nx = ST_DONE;
                    end else if (w_len_full > 32'(MEM_WORDS)) begin
                        w_state_nx = ST_ERR;
                    end else begin
                        w_state_nx = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_frame_err) begin
                    w_state_nx = ST_ERR;
                end else if (w_last_byte && (r_words_left == (ADDR_W+1)'(1))) begin
                    w_state_nx = ST_DONE;
                end
            end
            ST_DONE: w_state_nx = ST_DONE;
            ST_ERR:  w_state_nx = ST_ERR;
            default: w_state_nx = ST_ERR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_LEN;
            r_lane       <= '0;
            r_len        <= '0;
            r_word       <= '0;
            r_idx        <= '0;
            r_words_left <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_run    <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_mem_we   <= 1'b0;
            r_cpu_run  <= (r_state == ST_DONE);
            r_load_err <= r_load_err | (r_state == ST_ERR);
            if (w_loading && w_rx_valid) begin
                r_lane <= r_lane + 1'b1;
                if (r_state == ST_LEN) begin
                    r_len <= {w_rx_byte, r_len[23:8]};
                    if (w_last_byte && (w_state_nx == ST_DATA)) begin
                        r_words_left <= w_len_full[ADDR_W:0];
                    end
                end else begin
                    r_word <= {w_rx_byte, r_word[23:8]};
                    if (w_last_byte) begin
                        r_mem_we     <= 1'b1;
                        r_mem_wdata  <= w_word_full;
                        r_mem_addr   <= r_idx;
                        r_idx        <= r_idx + 1'b1;
                        r_words_left <= r_words_left - 1'b1;
                    end
                end
            end
        end
    end

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign cpu_run    = r_cpu_run;
    assign load_err   = r_load_err;
    assign words_left = r_words_left;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed and randomized image loads for uart_prog_loader, checked against a
// word-list model of the expected memory writes and final status.
module tb_uart_prog_loader;

    localparam int CLK_HZ    = 1_000_000;
    localparam int BAUD      = 100_000;
    localparam int CPB       = CLK_HZ / BAUD;
    localparam int MEM_WORDS = 2056;
    localparam int ADDR_W    = 12;
    localparam int W         = ADDR_W + 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ser_rx = 1'b1;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_run;
    logic              load_err;
    logic [ADDR_W:0]   words_left;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic [31:0]  img_q[$];
    int cyc = 0;
    int last_we_cyc = -1;
    int run_cyc = -1;

    uart_prog_loader #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ser_rx     (ser_rx),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_run    (cpu_run),
        .load_err   (load_err),
        .words_left (words_left)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Write monitor: captures every strobe and when cpu_run first rises.
    always @(negedge clk) begin
        if (reset) begin
            got_q.delete();
            last_we_cyc = -1;
            run_cyc     = -1;
        end else begin
            cyc++;
            if (mem_we) begin
                got_q.push_back({mem_addr, mem_wdata});
                last_we_cyc = cyc;
            end
            if (cpu_run && run_cyc < 0) run_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        ser_rx = 1'b1;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
    endtask

    // Driver: one 8N1 frame, optionally with a zero stop bit.
    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        ser_rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        ser_rx = !bad_stop;
        repeat (CPB) @(posedge clk);
        ser_rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], 1'b0);
            repeat ($urandom_range(0, gap_max)) @(posedge clk);
        end
    endtask

    // Reference model: word i of the image lands at index i.
    task automatic send_image(input int gap_max);
        send_word(32'(img_q.size()), gap_max);
        for (int i = 0; i < img_q.size(); i++) begin
            exp_q.push_back({ADDR_W'(i), img_q[i]});
            send_word(img_q[i], gap_max);
        end
    endtask

    task automatic check_loaded(input string tag);
        repeat (40) @(posedge clk);
        #1;
        chk({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_write%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        end
        chk({tag, "_cpu_run"}, 64'(cpu_run), 64'd1);
        chk({tag, "_load_err"}, 64'(load_err), 64'd0);
        chk({tag, "_words_left"}, 64'(words_left), 64'd0);
        if (exp_q.size() > 0) begin
            chk({tag, "_run_latency"}, 64'(run_cyc - last_we_cyc), 64'd1);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, "_cpu_run"}, 64'(cpu_run), 64'd0);
        chk({tag, "_load_err"}, 64'(load_err), 64'd0);
        chk({tag, "_words_left"}, 64'(words_left), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        do_reset();

        // Two-word image
        img_q = '{32'h0000_0013, 32'hDEAD_BEEF};
        send_image(0);
        check_loaded("n2");

        // Empty image
        do_reset();
        img_q.delete();
        send_image(3);
        check_loaded("n0");

        // Oversized length, followed by bytes that must not be written
        do_reset();
        send_word(32'(MEM_WORDS + 1), 0);
        send_word(32'hCAFE_F00D, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("toolong_load_err", 64'(load_err), 64'd1);
        chk("toolong_cpu_run", 64'(cpu_run), 64'd0);
        chk("toolong_nwrites", 64'(got_q.size()), 64'd0);

        // Frame error on byte 2 of word 0
        do_reset();
        send_word(32'd1, 0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        chk("ferr_load_err", 64'(load_err), 64'd1);
        chk("ferr_cpu_run", 64'(cpu_run), 64'd0);
        chk("ferr_nwrites", 64'(got_q.size()), 64'd0);
        reset = 1'b1;
        #1 check_zero("ferr_reset");
        do_reset();

        // Short low glitch is a false start, then a normal load
        ser_rx = 1'b0;
        repeat (4) @(posedge clk);
        ser_rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("glitch_nwrites", 64'(got_q.size()), 64'd0);
        chk("glitch_load_err", 64'(load_err), 64'd0);
        chk("glitch_cpu_run", 64'(cpu_run), 64'd0);
        img_q = '{$urandom()};
        send_image(2);
        check_loaded("glitch_load");

        // Reset in the middle of a byte of word 1, then a fresh image
        do_reset();
        send_word(32'd3, 0);
        send_word(32'hA5A5_0001, 0);
        send_byte(8'h01, 1'b0);
        ser_rx = 1'b0;
        repeat (CPB + 4) @(posedge clk);
        #3 reset = 1'b1;
        #1 check_zero("midreset");
        do_reset();
        img_q = '{32'h1234_5678};
        send_image(0);
        check_loaded("after_midreset");

        // Randomized images with random inter-byte gaps
        for (int t = 0; t < 4; t++) begin
            do_reset();
            img_q.delete();
            repeat ($urandom_range(1, 6)) img_q.push_back($urandom());
            send_image(15);
            check_loaded($sformatf("rand%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
